// File: rtl/rx_pkg.sv
// Shared definitions for the receive-path frame parser.
// State encoding and CRC-16/MODBUS constants.
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATA_LO = 3'd1,
    DATA_HI = 3'd2,
    CRC_LO  = 3'd3,
    CRC_HI  = 3'd4
  } state_t;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

endpackage

// File: rtl/crc16_modbus_byte.sv
// One-byte CRC-16/MODBUS update, fully combinational.
// Ports: crc_in (running crc), byte_in (data byte) -> crc_out.
module crc16_modbus_byte
  import rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // Reflected algorithm: fold the byte into the low half, then
  // eight LSB-first shift/xor steps unrolled into one cycle.
  always_comb begin
    c = crc_in ^ {8'h00, byte_in};
    for (int i = 0; i < 8; i++) begin
      if (c[0])
        c = (c >> 1) ^ CRC_POLY;
      else
        c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/rx_frame_parser.sv
// Frame parser: START_BYTE, n_word LE words, CRC-16/MODBUS.
// Ports: clk, reset, byte_in/byte_strb in; select, data_out,
// data_strb, crc_valid, crc_error, timeout_err, busy out.
module rx_frame_parser
  import rx_pkg::*;
#(
  parameter logic [7:0]  n_word      = 8'h01,
  parameter logic [7:0]  START_BYTE  = 8'hA5,
  parameter logic [15:0] TIMEOUT_CLK = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_strb,
  output logic [7:0]  select,
  output logic [15:0] data_out,
  output logic        data_strb,
  output logic        crc_valid,
  output logic        crc_error,
  output logic        timeout_err,
  output logic        busy
);

  state_t      state;
  logic [7:0]  idx;
  logic [7:0]  lo_q;
  logic [7:0]  crc_lo_q;
  logic [15:0] crc_q;
  logic [15:0] crc_nxt;
  logic [15:0] tmo_q;
  logic        tmo_hit;
  logic        last_word;

  crc16_modbus_byte u_crc (
    .crc_in  (crc_q),
    .byte_in (byte_in),
    .crc_out (crc_nxt)
  );

  // Fires on the edge where the idle count would reach
  // TIMEOUT_CLK-1; a coincident byte always wins.
  assign tmo_hit = (state != IDLE) && !byte_strb &&
                   (tmo_q == TIMEOUT_CLK - 16'd2);

  assign last_word = (idx == n_word - 8'd1);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 8'd0;
      lo_q        <= 8'd0;
      crc_lo_q    <= 8'd0;
      crc_q       <= 16'd0;
      tmo_q       <= 16'd0;
      select      <= 8'd0;
      data_out    <= 16'd0;
      data_strb   <= 1'b0;
      crc_valid   <= 1'b0;
      crc_error   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      data_strb   <= 1'b0;
      crc_valid   <= 1'b0;
      crc_error   <= 1'b0;
      timeout_err <= 1'b0;

      if (state == IDLE || byte_strb)
        tmo_q <= 16'd0;
      else
        tmo_q <= tmo_q + 16'd1;

      if (tmo_hit) begin
        state       <= IDLE;
        timeout_err <= 1'b1;
      end else if (byte_strb) begin
        unique case (state)
          IDLE: begin
            if (byte_in == START_BYTE) begin
              state <= DATA_LO;
              crc_q <= CRC_INIT;
              idx   <= 8'd0;
            end
          end
          DATA_LO: begin
            lo_q  <= byte_in;
            crc_q <= crc_nxt;
            state <= DATA_HI;
          end
          DATA_HI: begin
            crc_q     <= crc_nxt;
            data_out  <= {byte_in, lo_q};
            select    <= idx;
            data_strb <= 1'b1;
            if (last_word) begin
              state <= CRC_LO;
            end else begin
              idx   <= idx + 8'd1;
              state <= DATA_LO;
            end
          end
          CRC_LO: begin
            crc_lo_q <= byte_in;
            state    <= CRC_HI;
          end
          CRC_HI: begin
            if ({byte_in, crc_lo_q} == crc_q)
              crc_valid <= 1'b1;
            else
              crc_error <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
